// File: rtl/pcounter_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : pcounter_cfg_master
// Description : Initiator for the pcounter SRAM-like configuration port.
//               Takes read/write commands on a valid/ready port, issues each
//               one as a single-cycle cfg_enable access, and returns a write
//               ack, captured read data or an address error on a valid/ready
//               response port. One command outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module pcounter_cfg_master #(
    parameter int ADDR_W     = 3,
    parameter int DATA_W     = 10,
    parameter int NUM_REGS   = 4,
    parameter int RD_LATENCY = 2    // legal range 1..7
) (
    input  logic              clk,
    input  logic              rst,
    // command port
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response port
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    // pcounter configuration bus
    output logic              cfg_enable,
    output logic              cfg_rd_wr,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [DATA_W-1:0] cfg_wdata,
    input  logic [DATA_W-1:0] cfg_rdata,
    // status
    output logic              busy
);

    // FSM encoding
    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ISSUE   = 2'd1;
    localparam logic [1:0] c_WAIT_RD = 2'd2;
    localparam logic [1:0] c_RESP    = 2'd3;

    // A register count larger than the address space decodes every address.
    localparam int              c_NR_CLAMP  = (NUM_REGS > (2 ** ADDR_W)) ? (2 ** ADDR_W) : NUM_REGS;
    localparam logic [ADDR_W:0] c_NUM_REGS  = c_NR_CLAMP[ADDR_W:0];

    // Wait counter is loaded with RD_LATENCY-1 (at most 6) in the issue cycle.
    localparam int              c_CNT_W     = 3;
    localparam logic [c_CNT_W-1:0] c_RD_LOAD = c_CNT_W'(RD_LATENCY - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_cmd_ready;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic               r_rsp_err;
    logic               r_cfg_enable;
    logic               r_cfg_rd_wr;
    logic [ADDR_W-1:0]  r_cfg_addr;
    logic [DATA_W-1:0]  r_cfg_wdata;
    logic               r_busy;

    logic               w_addr_ok;

    // Address decode on the incoming command (zero-extended compare).
    assign w_addr_ok = ({1'b0, cmd_addr} < c_NUM_REGS);

    // Transaction sequencer: every output is a register updated here, so
    // nothing reaches an output combinationally from an input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_err    <= 1'b0;
            r_cfg_enable <= 1'b0;
            r_cfg_rd_wr  <= 1'b0;
            r_cfg_addr   <= '0;
            r_cfg_wdata  <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_addr_ok) begin
                            // The cfg bus fields double as the latched command;
                            // they only change when an access is really issued.
                            r_cfg_rd_wr  <= cmd_rd_wr;
                            r_cfg_addr   <= cmd_addr;
                            r_cfg_wdata  <= cmd_wdata;
                            r_cfg_enable <= 1'b1;
                            r_state      <= c_ISSUE;
                        end else begin
                            // Out-of-range: answer with an error, no bus access.
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= c_RESP;
                        end
                    end
                end
                c_ISSUE: begin
                    r_cfg_enable <= 1'b0;
                    if (r_cfg_rd_wr) begin
                        r_cnt   <= c_RD_LOAD;
                        r_state <= c_WAIT_RD;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= '0;
                        r_state     <= c_RESP;
                    end
                end
                c_WAIT_RD: begin
                    if (r_cnt == '0) begin
                        r_rsp_rdata <= cfg_rdata;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= c_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_cmd_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_rsp_valid  <= 1'b0;
                    r_cfg_enable <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_err    = r_rsp_err;
    assign cfg_enable = r_cfg_enable;
    assign cfg_rd_wr  = r_cfg_rd_wr;
    assign cfg_addr   = r_cfg_addr;
    assign cfg_wdata  = r_cfg_wdata;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_pcounter_cfg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_pcounter_cfg_master
// Description : Self-checking bench for pcounter_cfg_master. A pcounter slave
//               model answers cfg accesses; a register-level reference model
//               predicts every response and its latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pcounter_cfg_master;

    localparam int AW = 3;
    localparam int DW = 10;
    localparam int NR = 4;
    localparam int RL = 2;

    logic          clk;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_rd_wr;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          cfg_enable, cfg_rd_wr;
    logic [AW-1:0] cfg_addr;
    logic [DW-1:0] cfg_wdata, cfg_rdata;
    logic          busy;

    // second instance built with RD_LATENCY=1
    logic          cmd_valid1, cmd_ready1, cmd_rd_wr1;
    logic [AW-1:0] cmd_addr1;
    logic [DW-1:0] cmd_wdata1;
    logic          rsp_valid1, rsp_ready1, rsp_err1;
    logic [DW-1:0] rsp_rdata1;
    logic          cfg_enable1, cfg_rd_wr1;
    logic [AW-1:0] cfg_addr1;
    logic [DW-1:0] cfg_wdata1, cfg_rdata1;
    logic          busy1;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: register contents as seen through the command port
    logic [DW-1:0] ref_regs [NR];
    // slave model storage and bookkeeping
    logic [DW-1:0] slave_mem [NR];
    logic [DW-1:0] slave_mem1 [NR];
    int            enable_cnt = 0;
    int            ncyc = 0, due = 0;
    bit            pend = 0;
    logic [DW-1:0] due_data;
    int            ncyc1 = 0, due1 = 0;
    bit            pend1 = 0;
    logic [DW-1:0] due_data1;

    pcounter_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LATENCY(RL)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd_wr(cmd_rd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_enable(cfg_enable), .cfg_rd_wr(cfg_rd_wr), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .busy(busy)
    );

    pcounter_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .RD_LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_rd_wr(cmd_rd_wr1),
        .cmd_addr(cmd_addr1), .cmd_wdata(cmd_wdata1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1),
        .cfg_enable(cfg_enable1), .cfg_rd_wr(cfg_rd_wr1), .cfg_addr(cfg_addr1),
        .cfg_wdata(cfg_wdata1), .cfg_rdata(cfg_rdata1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // pcounter slave: data for a read is valid exactly in the cycle RL cycles
    // after the enable cycle; every other cycle carries random junk.
    always @(negedge clk) begin
        ncyc = ncyc + 1;
        if (pend && ncyc == due) begin
            cfg_rdata = due_data;
            pend = 0;
        end else begin
            cfg_rdata = DW'($urandom);
        end
        if (cfg_enable === 1'b1) begin
            enable_cnt = enable_cnt + 1;
            if (cfg_rd_wr) begin
                pend = 1;
                due = ncyc + RL;
                due_data = slave_mem[cfg_addr[1:0]];
            end else begin
                slave_mem[cfg_addr[1:0]] = cfg_wdata;
            end
        end
    end

    // pcounter slave for the RD_LATENCY=1 instance
    always @(negedge clk) begin
        ncyc1 = ncyc1 + 1;
        if (pend1 && ncyc1 == due1) begin
            cfg_rdata1 = due_data1;
            pend1 = 0;
        end else begin
            cfg_rdata1 = DW'($urandom);
        end
        if (cfg_enable1 === 1'b1 && cfg_rd_wr1 === 1'b1) begin
            pend1 = 1;
            due1 = ncyc1 + 1;
            due_data1 = slave_mem1[cfg_addr1[1:0]];
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One complete command on the RL=2 instance. Called and returns just
    // after a falling edge. hold = extra cycles rsp_ready stays low once the
    // response is up; ready_early drives rsp_ready high from the start.
    task automatic run_cmd(input bit rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input bit ready_early, input int hold);
        bit            err_exp;
        logic [DW-1:0] data_exp;
        int            lat_exp;
        int            lat;
        int            en_seen;
        bit            ready_bad;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic          s_rd;
        err_exp  = (int'(addr) >= NR);
        data_exp = (rd && !err_exp) ? ref_regs[addr[1:0]] : '0;
        lat_exp  = rd ? 2 + RL : 2;
        lat = -1; en_seen = 0; ready_bad = 0;
        s_addr = '0; s_wdata = '0; s_rd = 1'b0;

        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_cmd_ready: got %b expected 1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_rd_wr = rd; cmd_addr = addr; cmd_wdata = wd;
        rsp_ready = ready_early;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_wdata = DW'($urandom);
            end
            if (cfg_enable === 1'b1) begin
                en_seen++;
                s_addr = cfg_addr; s_wdata = cfg_wdata; s_rd = cfg_rd_wr;
            end
            if (cmd_ready !== 1'b0 || busy !== 1'b1) ready_bad = 1;
            if (rsp_valid === 1'b1) begin
                lat = k;
                break;
            end
        end

        n_checks++;
        if (lat < 0) begin
            n_errors++;
            $display("FAIL rsp_timeout: no rsp_valid within 20 cycles (addr %0d rd %0d)", addr, rd);
        end
        n_checks++;
        if (ready_bad) begin
            n_errors++;
            $display("FAIL busy_flags: cmd_ready/busy wrong while command in flight");
        end
        n_checks++;
        if (en_seen != (err_exp ? 0 : 1)) begin
            n_errors++;
            $display("FAIL enable_count: got %0d pulses expected %0d", en_seen, err_exp ? 0 : 1);
        end
        if (!err_exp) begin
            n_checks++;
            if (s_addr !== addr || s_rd !== rd || (!rd && s_wdata !== wd)) begin
                n_errors++;
                $display("FAIL cfg_fields: got rd=%b addr=%0d wdata=%0d expected rd=%b addr=%0d wdata=%0d",
                         s_rd, s_addr, s_wdata, rd, addr, wd);
            end
            n_checks++;
            if (lat != lat_exp) begin
                n_errors++;
                $display("FAIL latency: got %0d cycles expected %0d", lat, lat_exp);
            end
        end
        n_checks++;
        if (rsp_err !== err_exp || rsp_rdata !== data_exp) begin
            n_errors++;
            $display("FAIL response: got err=%b rdata=%0d expected err=%b rdata=%0d",
                     rsp_err, rsp_rdata, err_exp, data_exp);
        end

        if (!ready_early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                n_checks++;
                if (rsp_valid !== 1'b1 || rsp_err !== err_exp || rsp_rdata !== data_exp ||
                    cfg_enable !== 1'b0 || cmd_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rsp_hold: got valid=%b err=%b rdata=%0d en=%b rdy=%b expected 1 %b %0d 0 0",
                             rsp_valid, rsp_err, rsp_rdata, cfg_enable, cmd_ready, err_exp, data_exp);
                end
            end
            rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL handshake: got valid=%b cmd_ready=%b busy=%b expected 0 1 0",
                     rsp_valid, cmd_ready, busy);
        end

        if (!rd && !err_exp) ref_regs[addr[1:0]] = wd;
    endtask

    task automatic test_reset();
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || cfg_enable !== 1'b0 || busy !== 1'b0 ||
            rsp_rdata !== '0 || rsp_err !== 1'b0 || cfg_addr !== '0 || cfg_wdata !== '0 ||
            cfg_rd_wr !== 1'b0 || cmd_ready1 !== 1'b1 || rsp_valid1 !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b en=%b busy=%b rdata=%0d err=%b expected 1 0 0 0 0 0",
                     cmd_ready, rsp_valid, cfg_enable, busy, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_write();
        run_cmd(1'b0, 3'd2, 10'd200, 1'b0, 0);
    endtask

    task automatic test_read();
        run_cmd(1'b0, 3'd1, 10'd10, 1'b0, 0);
        run_cmd(1'b1, 3'd1, 10'd0, 1'b0, 2);
    endtask

    task automatic test_bad_addr();
        run_cmd(1'b0, 3'd5, 10'd77, 1'b0, 1);
        run_cmd(1'b1, 3'd7, 10'd0, 1'b1, 0);
        run_cmd(1'b1, 3'd4, 10'd0, 1'b0, 0);
    endtask

    // First response held 5 cycles while a second command waits.
    task automatic test_back_to_back();
        logic [DW-1:0] a;
        int            snap;
        int            lat;
        a = DW'($urandom);
        snap = enable_cnt;
        cmd_valid = 1'b1; cmd_rd_wr = 1'b0; cmd_addr = 3'd0; cmd_wdata = a;
        @(negedge clk);
        cmd_rd_wr = 1'b1; cmd_wdata = '0;   // second command: read back addr 0
        lat = -1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++;
        if (lat != 2) begin
            n_errors++;
            $display("FAIL b2b_first_latency: got %0d expected 2", lat);
        end
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== '0 ||
                cmd_ready !== 1'b0 || enable_cnt != snap + 1) begin
                n_errors++;
                $display("FAIL b2b_hold: got valid=%b err=%b rdata=%0d rdy=%b enables=%0d expected 1 0 0 0 %0d",
                         rsp_valid, rsp_err, rsp_rdata, cmd_ready, enable_cnt - snap, 1);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || enable_cnt != snap + 1) begin
            n_errors++;
            $display("FAIL b2b_release: got valid=%b rdy=%b enables=%0d expected 0 1 1",
                     rsp_valid, cmd_ready, enable_cnt - snap);
        end
        ref_regs[0] = a;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin lat = k; break; end
        end
        n_checks++;
        if (lat != 1 + RL || rsp_rdata !== ref_regs[0] || rsp_err !== 1'b0 || enable_cnt != snap + 2) begin
            n_errors++;
            $display("FAIL b2b_second: got lat=%0d rdata=%0d err=%b enables=%0d expected %0d %0d 0 2",
                     lat, rsp_rdata, rsp_err, enable_cnt - snap, 1 + RL, ref_regs[0]);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    // Asynchronous reset while a read waits for data.
    task automatic test_async_reset();
        cmd_valid = 1'b1; cmd_rd_wr = 1'b1; cmd_addr = 3'd1; cmd_wdata = '0;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || cfg_enable !== 1'b0 || busy !== 1'b0 ||
            rsp_rdata !== '0 || rsp_err !== 1'b0 || cfg_addr !== '0 || cfg_rd_wr !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: got rdy=%b vld=%b en=%b busy=%b addr=%0d rd=%b expected 1 0 0 0 0 0",
                     cmd_ready, rsp_valid, cfg_enable, busy, cfg_addr, cfg_rd_wr);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_checks++;
            if (rsp_valid !== 1'b0 || cfg_enable !== 1'b0 || cmd_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL post_reset_quiet: got vld=%b en=%b rdy=%b expected 0 0 1",
                         rsp_valid, cfg_enable, cmd_ready);
            end
        end
    endtask

    task automatic test_random();
        bit            rd;
        logic [AW-1:0] addr;
        for (int i = 0; i < 40; i++) begin
            rd   = 1'($urandom);
            addr = AW'($urandom_range(0, 7));
            run_cmd(rd, addr, DW'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    // RD_LATENCY=1 instance: read addr 3 returning 1.
    task automatic test_rd_latency1();
        int lat;
        int en_seen;
        lat = -1; en_seen = 0;
        cmd_valid1 = 1'b1; cmd_rd_wr1 = 1'b1; cmd_addr1 = 3'd3; cmd_wdata1 = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) cmd_valid1 = 1'b0;
            if (cfg_enable1 === 1'b1) en_seen++;
            if (rsp_valid1 === 1'b1) begin lat = k; break; end
        end
        n_checks++;
        if (lat != 3 || en_seen != 1) begin
            n_errors++;
            $display("FAIL rl1_timing: got lat=%0d enables=%0d expected 3 1", lat, en_seen);
        end
        n_checks++;
        if (rsp_rdata1 !== 10'd1 || rsp_err1 !== 1'b0) begin
            n_errors++;
            $display("FAIL rl1_data: got rdata=%0d err=%b expected 1 0", rsp_rdata1, rsp_err1);
        end
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
        n_checks++;
        if (rsp_valid1 !== 1'b0 || cmd_ready1 !== 1'b1) begin
            n_errors++;
            $display("FAIL rl1_handshake: got vld=%b rdy=%b expected 0 1", rsp_valid1, cmd_ready1);
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_rd_wr = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        cmd_valid1 = 1'b0; cmd_rd_wr1 = 1'b0; cmd_addr1 = '0; cmd_wdata1 = '0; rsp_ready1 = 1'b0;
        cfg_rdata = '0; cfg_rdata1 = '0;
        for (int i = 0; i < NR; i++) begin
            v = DW'($urandom);
            slave_mem[i] = v;
            ref_regs[i]  = v;
            slave_mem1[i] = DW'($urandom);
        end
        slave_mem1[3] = 10'd1;
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_write();
        test_read();
        test_bad_addr();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_rd_latency1();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
